// File: rtl/serial_out_fifo_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// PARITY is only reachable when SERIAL_OUT_FIFO_PARITY_EN is defined.
package serial_pkg;

    localparam int DATA_BITS      = 8;
    localparam int DEF_BAUD_DIV   = 434;
    localparam int DEF_FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/serial_out_fifo_if.sv
// Character input and status/line outputs of serial_out_fifo, bundled as one port.
interface serial_out_fifo_if
    import serial_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] char;
    logic                 valid;
    logic                 uart_tx;
    logic                 full;
    logic                 empty;
    logic                 busy;
    logic                 overflow;
    logic [LW-1:0]        level;

    modport master (
        output char, valid,
        input  uart_tx, full, empty, busy, overflow, level
    );

    modport slave (
        input  char, valid,
        output uart_tx, full, empty, busy, overflow, level
    );

endinterface

// File: rtl/serial_out_fifo_sync_fifo.sv
// Circular-buffer FIFO with registered full/empty/level and a same-cycle
// (combinational) read of the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_level;
    logic             r_full;
    logic             r_empty;
    logic [AW:0]      w_wr_ptr_next;
    logic [AW:0]      w_rd_ptr_next;
    logic [AW:0]      w_level_next;

    always_comb begin
        w_wr_ptr_next = r_wr_ptr + {{AW{1'b0}}, push};
        w_rd_ptr_next = r_rd_ptr + {{AW{1'b0}}, pop};
        w_level_next  = w_wr_ptr_next - w_rd_ptr_next;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointers carry one extra MSB so full and empty differ only in that bit.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_level  <= w_level_next;
            r_full   <= (w_wr_ptr_next[AW] != w_rd_ptr_next[AW]) &&
                        (w_wr_ptr_next[AW-1:0] == w_rd_ptr_next[AW-1:0]);
            r_empty  <= (w_wr_ptr_next == w_rd_ptr_next);
        end
    end

    assign dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign full  = r_full;
    assign empty = r_empty;
    assign level = r_level;

endmodule

// File: rtl/serial_out_fifo.sv
// Buffered UART transmitter: valid edge detect, FIFO with overflow flag, 8N1 framer.
// Define SERIAL_OUT_FIFO_PARITY_EN to append an even-parity bit (11-bit frames).
module serial_out_fifo
    import serial_pkg::*;
#(
    parameter int BAUD_DIV   = DEF_BAUD_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               nrst,
    serial_out_fifo_if.slave   sout
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(BAUD_DIV);

    tx_state_t            r_state, w_state_next;
    logic [CW-1:0]        r_cnt, w_cnt_next;
    logic [2:0]           r_bit, w_bit_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_tx, w_tx_next;
    logic                 r_valid_d;
    logic                 r_overflow;
`ifdef SERIAL_OUT_FIFO_PARITY_EN
    logic                 r_parity, w_parity_next;
`endif

    logic                 w_push, w_pop, w_accept, w_bit_end;
    logic                 w_full, w_empty;
    logic [LW-1:0]        w_level;
    logic [DATA_BITS-1:0] w_fifo_dout;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push    = sout.valid & ~r_valid_d;
    assign w_accept  = w_push & (~w_full | w_pop);
    assign w_bit_end = (r_cnt == CW'(BAUD_DIV - 1));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (w_accept),
        .pop   (w_pop),
        .din   (sout.char),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // Line value is computed for the next state so uart_tx leaves a flop directly.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = (r_state == IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
`ifdef SERIAL_OUT_FIFO_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_state_next = START;
                    w_tx_next    = 1'b0;
`ifdef SERIAL_OUT_FIFO_PARITY_EN
                    w_parity_next = ^w_fifo_dout;
`endif
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                    w_bit_next   = '0;
                    w_tx_next    = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'(DATA_BITS - 1)) begin
`ifdef SERIAL_OUT_FIFO_PARITY_EN
                        w_state_next = PARITY;
                        w_tx_next    = r_parity;
`else
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
`endif
                    end else begin
                        w_bit_next   = r_bit + 1'b1;
                        w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_next    = r_shift[1];
                    end
                end
            end
`ifdef SERIAL_OUT_FIFO_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                    w_tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_dout;
                        w_state_next = START;
                        w_tx_next    = 1'b0;
`ifdef SERIAL_OUT_FIFO_PARITY_EN
                        w_parity_next = ^w_fifo_dout;
`endif
                    end else begin
                        w_state_next = IDLE;
                        w_tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_valid_d  <= 1'b0;
            r_overflow <= 1'b0;
`ifdef SERIAL_OUT_FIFO_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit      <= w_bit_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_valid_d  <= sout.valid;
            r_overflow <= r_overflow | (w_push & ~w_accept);
`ifdef SERIAL_OUT_FIFO_PARITY_EN
            r_parity   <= w_parity_next;
`endif
        end
    end

    assign sout.uart_tx  = r_tx;
    assign sout.full     = w_full;
    assign sout.empty    = w_empty;
    assign sout.level    = w_level;
    assign sout.overflow = r_overflow;
    assign sout.busy     = (r_state != IDLE) | ~w_empty;

endmodule

// File: tb/tb_serial_out_fifo.sv
// Directed bench for serial_out_fifo (BAUD_DIV=4, FIFO_DEPTH=4); frame bits are
// checked every cycle and an independent receiver decodes the line.
module tb_serial_out_fifo;
    import serial_pkg::*;

    localparam int B = 4;
    localparam int D = 4;
`ifdef SERIAL_OUT_FIFO_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    serial_out_fifo_if #(.FIFO_DEPTH(D)) sif ();

    serial_out_fifo #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (D)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .sout (sif.slave)
    );

    int         checks   = 0;
    int         failures = 0;
    int         hold_cnt = 0;
    int         lvl_max  = 0;
    int         n_low;
    logic [7:0] pend_q[$];
    logic [7:0] rx_q[$];
    logic       rx_abort;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit i of byte b: start, LSB-first data, [parity], stop.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (FL == 11 && i == 9) return ^b;
        return 1'b1;
    endfunction

    // Advance one cycle; also sequences valid pulses from the pending queue.
    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(sif.level) > lvl_max) lvl_max = int'(sif.level);
        if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) sif.valid = 1'b0;
        end else if (!sif.valid && pend_q.size() > 0) begin
            sif.char  = pend_q.pop_front();
            sif.valid = 1'b1;
            hold_cnt  = 1;
        end
    endtask

    task automatic push(input logic [7:0] b, input int n);
        sif.char  = b;
        sif.valid = 1'b1;
        hold_cnt  = n;
    endtask

    task automatic check_frame(input logic [7:0] b, input string tag);
        for (int i = 0; i < FL; i++) begin
            for (int c = 0; c < B; c++) begin
                chk($sformatf("%s_bit%0d_c%0d", tag, i, c), 32'(sif.uart_tx), 32'(exp_bit(b, i)));
                tick();
            end
        end
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (sif.busy !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(sif.busy), 32'd0);
    endtask

    task automatic count_low(input int n);
        n_low = 0;
        repeat (n) begin
            tick();
            if (sif.uart_tx !== 1'b1) n_low++;
        end
    endtask

    task automatic rx_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!nrst) rx_abort = 1'b1;
        end
    endtask

    // Mid-bit sampling receiver; frames cut short by reset are discarded.
    initial begin
        logic [7:0] d;
        logic       s;
`ifdef SERIAL_OUT_FIFO_PARITY_EN
        logic       p;
`endif
        forever begin
            @(posedge clk);
            #1;
            if (nrst === 1'b1 && sif.uart_tx === 1'b0) begin
                rx_abort = 1'b0;
                rx_wait(B / 2);
                for (int i = 0; i < 8; i++) begin
                    rx_wait(B);
                    d[i] = sif.uart_tx;
                end
`ifdef SERIAL_OUT_FIFO_PARITY_EN
                rx_wait(B);
                p = sif.uart_tx;
`endif
                rx_wait(B);
                s = sif.uart_tx;
                if (!rx_abort) begin
                    rx_q.push_back(d);
                    chk("rx_stop", 32'(s), 32'd1);
`ifdef SERIAL_OUT_FIFO_PARITY_EN
                    chk("rx_parity", 32'(p), 32'(^d));
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        sif.char  = 8'h00;
        sif.valid = 1'b0;
        nrst      = 1'b0;
        tick();
        tick();
        chk("rst_uart_tx", 32'(sif.uart_tx), 32'd1);
        chk("rst_full", 32'(sif.full), 32'd0);
        chk("rst_empty", 32'(sif.empty), 32'd1);
        chk("rst_busy", 32'(sif.busy), 32'd0);
        chk("rst_overflow", 32'(sif.overflow), 32'd0);
        chk("rst_level", 32'(sif.level), 32'd0);
        nrst = 1'b1;
        tick();

        // Single frame: push at cycle 0, start bit from cycle 2, busy low at 42
        push(8'h48, 1);
        tick();
        chk("t1_level_c1", 32'(sif.level), 32'd1);
        chk("t1_empty_c1", 32'(sif.empty), 32'd0);
        tick();
        chk("t1_busy_c2", 32'(sif.busy), 32'd1);
        check_frame(8'h48, "t1");
        chk("t1_busy_end", 32'(sif.busy), 32'd0);
        chk("t1_empty_end", 32'(sif.empty), 32'd1);
        chk("t1_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("t1_rx_data", 32'(rx_q[0]), 32'h48);
        rx_q.delete();

        // Level strobe: valid held 10 cycles -> one frame, level at most 1
        lvl_max = 0;
        push(8'h41, 10);
        tick();
        tick();
        check_frame(8'h41, "t2");
        count_low(2 * FL * B);
        chk("t2_no_extra_frame", 32'(n_low), 32'd0);
        chk("t2_level_max", 32'(lvl_max), 32'd1);
        chk("t2_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("t2_rx_data", 32'(rx_q[0]), 32'h41);
        rx_q.delete();

        // Overflow: six pushes two cycles apart into a depth-4 FIFO
        push(8'hC1, 1);
        pend_q = '{8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        repeat (9) tick();
        chk("t3_full_c9", 32'(sif.full), 32'd1);
        chk("t3_level_c9", 32'(sif.level), 32'd4);
        chk("t3_ovf_c9", 32'(sif.overflow), 32'd0);
        tick();
        tick();
        chk("t3_ovf_c11", 32'(sif.overflow), 32'd1);
        chk("t3_level_c11", 32'(sif.level), 32'd4);
        wait_idle(6 * FL * B + 20, "t3_idle_timeout");
        chk("t3_rx_count", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) chk($sformatf("t3_rx_data%0d", i), 32'(rx_q[i]), 32'(8'hC1 + i));
        end
        chk("t3_ovf_sticky", 32'(sif.overflow), 32'd1);
        rx_q.delete();

        nrst = 1'b0;
        tick();
        chk("t3_ovf_cleared", 32'(sif.overflow), 32'd0);
        #2 nrst = 1'b1;
        tick();

        // Back-to-back: three frames with no idle gap, 120 cycles total
        push(8'h01, 1);
        pend_q = '{8'h02, 8'h03};
        tick();
        tick();
        check_frame(8'h01, "t4_f1");
        chk("t4_level_c42", 32'(sif.level), 32'd1);
        check_frame(8'h02, "t4_f2");
        chk("t4_empty_c82", 32'(sif.empty), 32'd1);
        chk("t4_busy_c82", 32'(sif.busy), 32'd1);
        check_frame(8'h03, "t4_f3");
        chk("t4_busy_end", 32'(sif.busy), 32'd0);
        chk("t4_rx_count", 32'(rx_q.size()), 32'd3);
        rx_q.delete();

        // Reset during DATA bit 3 with two bytes queued
        push(8'hA5, 1);
        pend_q = '{8'h11, 8'h22};
        tick();
        tick();
        repeat (17) tick();
        chk("t5_bit3_line", 32'(sif.uart_tx), 32'(exp_bit(8'hA5, 4)));
        chk("t5_level_pre", 32'(sif.level), 32'd2);
        nrst = 1'b0;
        tick();
        chk("t5_uart_tx", 32'(sif.uart_tx), 32'd1);
        chk("t5_level", 32'(sif.level), 32'd0);
        chk("t5_busy", 32'(sif.busy), 32'd0);
        chk("t5_empty", 32'(sif.empty), 32'd1);
        #2 nrst = 1'b1;
        count_low(3 * FL * B);
        chk("t5_no_frames", 32'(n_low), 32'd0);
        chk("t5_rx_count", 32'(rx_q.size()), 32'd0);
        rx_q.delete();

        // Parity-sensitive bytes: odd (0x07) and even (0x03) bit counts
        push(8'h07, 1);
        tick();
        tick();
        check_frame(8'h07, "t6_f07");
        chk("t6_len_07", 32'(sif.busy), 32'd0);
        push(8'h03, 1);
        tick();
        tick();
        check_frame(8'h03, "t6_f03");
        chk("t6_len_03", 32'(sif.busy), 32'd0);
        chk("t6_rx_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() > 1) chk("t6_rx_data1", 32'(rx_q[1]), 32'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_out_fifo.md
Name: serial_out_fifo

Overview:
Buffered UART transmitter. It consumes the character stream (char/valid) that the SFR write block produces for the SOUT address and serialises it onto uart_tx. A FIFO decouples CPU output bursts from the slow line rate, so the brainfuck core never has to wait on a frame in flight. It replaces the direct, unbuffered serial-out path.

Parameters:
BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.
FIFO_DEPTH, 16, FIFO entries; must be a power of two, >= 2.

Ports:
clk  in  1  system clock
nrst  in  1  synchronous active-low reset
char  in  8  byte to transmit
valid  in  1  write strobe; level or pulse
uart_tx  out  1  serial line, idle high
full  out  1  FIFO holds FIFO_DEPTH entries
empty  out  1  FIFO holds 0 entries
busy  out  1  frame in progress or FIFO not empty
overflow  out  1  sticky: a byte was dropped
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is synchronous and active-low. After the first clk edge with nrst=0, all outputs take their reset values:
  - uart_tx=1, full=0, empty=1, busy=0, overflow=0, level=0.
  - The FSM goes to IDLE, both FIFO pointers go to 0 and the baud counter goes to 0.
- Reset mid-frame truncates the frame. The line returns high on the next edge, and all buffered data is discarded.
- Push on rising edge of valid:
  - valid_d is a register with reset value 0; a push occurs in a cycle where valid=1 and valid_d=0.
  - Holding valid high for N cycles pushes exactly one byte.
  - char is sampled in the push cycle.
- Push acceptance:
  - A push is accepted if level < FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set to 1. It stays 1 until reset.
- FIFO structure:
  - Circular buffer with $clog2(FIFO_DEPTH)+1-bit read and write pointers; wrap-around is by pointer MSB.
  - full, empty and level are registered, consistent with the pointers after each edge.
  - A simultaneous push and pop leaves level unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - The baud counter runs 0..BAUD_DIV-1 in every state except IDLE. A bit ends when the counter reaches BAUD_DIV-1.
  - IDLE: uart_tx=1. If not empty: pop, load the shift register, go to START.
  - START: uart_tx=0 for BAUD_DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, each held BAUD_DIV cycles; the bit index runs 0..7. After bit 7, go to STOP.
  - STOP: uart_tx=1 for BAUD_DIV cycles. At the end of STOP:
    - if not empty: pop and go directly to START (back-to-back frames, no idle cycle);
    - otherwise go to IDLE.
- Latency: push in cycle N into an empty FIFO with the FSM in IDLE.
  - Cycle N+1: level=1, and the pop happens.
  - uart_tx falls at cycle N+2.
- uart_tx is driven from a register (glitch-free).
- busy = (state != IDLE) | !empty.

Optional Feature:
SERIAL_OUT_FIFO_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for BAUD_DIV cycles. Frame length is 11 bits.
- Undefined: no PARITY state; frame length is 10 bits (8N1).
- The port list is identical in both cases.

Decomposition:
- Package serial_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP); PARITY is unused unless the macro is defined;
  - DATA_BITS=8;
  - default BAUD_DIV and FIFO_DEPTH constants.
- One sub-module, sync_fifo, parameterised by width and depth:
  - push/pop/din/dout/full/empty/level;
  - read data is valid in the pop cycle (combinational read of mem[rd_ptr]).
- serial_out_fifo contains the valid edge detector, the drop/overflow logic, the baud counter and the FSM.

Test Plan:
- Single frame (BAUD_DIV=4): push 0x48 at cycle 0 -> uart_tx=0 in cycles 2..5. Then the data bits 0,0,0,1,0,0,1,0 (LSB first) for 4 cycles each, then 1 for 4 cycles. busy falls at cycle 42. Total frame is 40 cycles.
- Level strobe: valid held high for 10 cycles with char=0x41 -> exactly one frame, and level never exceeds 1.
- Overflow (FIFO_DEPTH=4, BAUD_DIV=4): 6 pushes at 2-cycle spacing while transmitting.
  - Byte 1 pops immediately; bytes 2..5 fill the FIFO, full=1; byte 6 is dropped and overflow=1.
  - Exactly 5 frames are sent, in order.
- Back-to-back: push 0x01, 0x02, 0x03 in consecutive edges -> 3 contiguous frames. Each stop bit is followed directly by the next start bit; 120 cycles from the first start bit to the end of the last stop bit. empty=1 after the third pop.
- Reset mid-frame: assert nrst=0 for 1 cycle during DATA bit 3 with 2 bytes queued -> after that edge uart_tx=1, level=0, busy=0, and no further frames follow.
- Parity (macro defined): push 0x07 -> parity bit=1 between bit 7 and stop; push 0x03 -> parity bit=0. Frame length is 44 cycles.
